// File: rtl/pipe_id_hs.sv
// RV32I decode stage: combinational regfile read, scoreboard hazard stall, writeback bypass.
// One-cycle latency into a single output register; in_ready drops on hazard, flush or a held output.
module pipe_id_hs #(
  parameter int XLEN      = 32,
  parameter int ALUOP_L   = 5,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_inst,
  input  logic [XLEN-1:0]    in_pc,
  output logic [4:0]         rs1_idx,
  output logic [4:0]         rs2_idx,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    rs2_data,
  input  logic               wb_valid,
  input  logic [4:0]         wb_idx,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    pc_out,
  output logic [6:0]         op,
  output logic [4:0]         rd,
  output logic [ALUOP_L-1:0] alu_op,
  output logic               alu_c,
  output logic [XLEN-1:0]    opr1,
  output logic [XLEN-1:0]    opr2,
  output logic [XLEN-1:0]    val,
  output logic               jp_e,
  output logic               br_e,
  output logic               wb_e,
  output logic [1:0]         rw_e,
  output logic [1:0]         rw_len,
  output logic               illegal
);

  localparam logic [ALUOP_L-1:0] ALU_ADD  = ALUOP_L'(0);
  localparam logic [ALUOP_L-1:0] ALU_SUB  = ALUOP_L'(1);
  localparam logic [ALUOP_L-1:0] ALU_SLL  = ALUOP_L'(2);
  localparam logic [ALUOP_L-1:0] ALU_SLT  = ALUOP_L'(3);
  localparam logic [ALUOP_L-1:0] ALU_SLTU = ALUOP_L'(4);
  localparam logic [ALUOP_L-1:0] ALU_XOR  = ALUOP_L'(5);
  localparam logic [ALUOP_L-1:0] ALU_SRL  = ALUOP_L'(6);
  localparam logic [ALUOP_L-1:0] ALU_SRA  = ALUOP_L'(7);
  localparam logic [ALUOP_L-1:0] ALU_OR   = ALUOP_L'(8);
  localparam logic [ALUOP_L-1:0] ALU_AND  = ALUOP_L'(9);
  localparam logic [ALUOP_L-1:0] ALU_SEQ  = ALUOP_L'(10);
  localparam logic [ALUOP_L-1:0] ALU_PASS = ALUOP_L'(11);

  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [6:0]         op;
    logic [4:0]         rd;
    logic [ALUOP_L-1:0] alu_op;
    logic               alu_c;
    logic [XLEN-1:0]    opr1;
    logic [XLEN-1:0]    opr2;
    logic [XLEN-1:0]    val;
    logic               jp_e;
    logic               br_e;
    logic               wb_e;
    logic [1:0]         rw_e;
    logic [1:0]         rw_len;
    logic               illegal;
  } bundle_t;

  bundle_t         dec;
  bundle_t         bundle_q, bundle_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     sb_q, sb_d;
  logic [31:0]     wb_hit, pend;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [6:0]      opc;
  logic [2:0]      funct3;
  logic            alt;
  logic            use_rs1, use_rs2, legal;
  logic            hazard, accept;

  // OP_IMM and OP share the funct3 map; only OP uses inst[30] to pick SUB.
  function automatic logic [ALUOP_L-1:0] arith_op(input logic [2:0] f3, input logic alt_b,
                                                  input logic is_op);
    logic [ALUOP_L-1:0] r;
    case (f3)
      3'd0:    r = (is_op && alt_b) ? ALU_SUB : ALU_ADD;
      3'd1:    r = ALU_SLL;
      3'd2:    r = ALU_SLT;
      3'd3:    r = ALU_SLTU;
      3'd4:    r = ALU_XOR;
      3'd5:    r = alt_b ? ALU_SRA : ALU_SRL;
      3'd6:    r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  assign opc     = in_inst[6:0];
  assign funct3  = in_inst[14:12];
  assign alt     = in_inst[30];
  assign rs1_idx = in_inst[19:15];
  assign rs2_idx = in_inst[24:20];

  always_comb begin
    imm_i = XLEN'($signed(in_inst[31:20]));
    imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
    imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
  end

  // A writeback landing this cycle is forwarded and no longer counts as pending.
  always_comb begin
    wb_hit = '0;
    if (BYPASS_EN && wb_valid) wb_hit[wb_idx] = 1'b1;
    pend = sb_q & ~wb_hit;

    rs1_val = rs1_data;
    if (rs1_idx == 5'd0)       rs1_val = '0;
    else if (wb_hit[rs1_idx])  rs1_val = wb_data;

    rs2_val = rs2_data;
    if (rs2_idx == 5'd0)       rs2_val = '0;
    else if (wb_hit[rs2_idx])  rs2_val = wb_data;
  end

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.op     = opc;
    dec.rd     = in_inst[11:7];
    dec.alu_op = ALU_PASS;
    legal      = 1'b1;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    case (opc)
      OPC_LUI: begin
        dec.opr1 = imm_u;
        dec.wb_e = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_op = ALU_ADD;
        dec.opr1   = in_pc;
        dec.opr2   = imm_u;
        dec.wb_e   = 1'b1;
      end
      OPC_JAL: begin
        dec.alu_op = ALU_ADD;
        dec.opr1   = imm_j;
        dec.opr2   = in_pc;
        dec.val    = XLEN'(4);
        dec.jp_e   = 1'b1;
        dec.wb_e   = 1'b1;
      end
      OPC_JALR: begin
        use_rs1    = 1'b1;
        legal      = (funct3 == 3'd0);
        dec.alu_op = ALU_ADD;
        dec.opr1   = rs1_val;
        dec.opr2   = imm_i;
        dec.val    = XLEN'(4);
        dec.jp_e   = 1'b1;
        dec.wb_e   = 1'b1;
      end
      OPC_OP_IMM: begin
        use_rs1    = 1'b1;
        dec.alu_op = arith_op(funct3, alt, 1'b0);
        dec.opr1   = rs1_val;
        dec.opr2   = imm_i;
        dec.wb_e   = 1'b1;
      end
      OPC_OP: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        dec.alu_op = arith_op(funct3, alt, 1'b1);
        dec.opr1   = rs1_val;
        dec.opr2   = rs2_val;
        dec.wb_e   = 1'b1;
      end
      OPC_LOAD: begin
        use_rs1    = 1'b1;
        legal      = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        dec.alu_op = ALU_ADD;
        dec.opr1   = rs1_val;
        dec.opr2   = imm_i;
        dec.rw_e   = funct3[2] ? 2'b11 : 2'b10;
        dec.rw_len = (funct3[1:0] == 2'b10) ? 2'b11 : funct3[1:0];
        dec.wb_e   = 1'b1;
      end
      OPC_STORE: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        legal      = funct3 inside {3'd0, 3'd1, 3'd2};
        dec.alu_op = ALU_ADD;
        dec.opr1   = rs1_val;
        dec.opr2   = imm_s;
        dec.val    = rs2_val;
        dec.rw_e   = 2'b01;
        dec.rw_len = (funct3[1:0] == 2'b10) ? 2'b11 : funct3[1:0];
      end
      OPC_BRANCH: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        legal      = funct3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        dec.alu_op = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SEQ;
        dec.alu_c  = funct3[0];
        dec.opr1   = rs1_val;
        dec.opr2   = rs2_val;
        dec.val    = imm_b;
        dec.br_e   = 1'b1;
      end
      OPC_MISC_MEM: legal = funct3 inside {3'd0, 3'd1};
      OPC_SYSTEM:   legal = (funct3 != 3'd4);
      default:      legal = 1'b0;
    endcase
    // Illegal bundles still flow to EX, but must not write anything or steer control flow.
    if (!legal) begin
      dec.alu_op  = ALU_PASS;
      dec.alu_c   = 1'b0;
      dec.opr1    = '0;
      dec.opr2    = '0;
      dec.val     = '0;
      dec.jp_e    = 1'b0;
      dec.br_e    = 1'b0;
      dec.wb_e    = 1'b0;
      dec.rw_e    = 2'b00;
      dec.rw_len  = 2'b00;
      dec.illegal = 1'b1;
    end
  end

  assign hazard   = (use_rs1 && pend[rs1_idx]) || (use_rs2 && pend[rs2_idx]) ||
                    (dec.wb_e && (dec.rd != 5'd0) && pend[dec.rd]);
  assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      bundle_d    = dec;
      out_valid_d = 1'b1;
    end else if (flush || out_ready) begin
      out_valid_d = 1'b0;
    end

    // Order matters: writeback clear, then accept set, then flush kill of the held writer.
    sb_d = sb_q;
    if (wb_valid) sb_d[wb_idx] = 1'b0;
    if (accept && dec.wb_e && (dec.rd != 5'd0)) sb_d[dec.rd] = 1'b1;
    if (flush && out_valid_q && bundle_q.wb_e) sb_d[bundle_q.rd] = 1'b0;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
      sb_q        <= '0;
    end else begin
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
      sb_q        <= sb_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pc_out    = bundle_q.pc;
  assign op        = bundle_q.op;
  assign rd        = bundle_q.rd;
  assign alu_op    = bundle_q.alu_op;
  assign alu_c     = bundle_q.alu_c;
  assign opr1      = bundle_q.opr1;
  assign opr2      = bundle_q.opr2;
  assign val       = bundle_q.val;
  assign jp_e      = bundle_q.jp_e;
  assign br_e      = bundle_q.br_e;
  assign wb_e      = bundle_q.wb_e;
  assign rw_e      = bundle_q.rw_e;
  assign rw_len    = bundle_q.rw_len;
  assign illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_pipe_id_hs.sv
// Scoreboard bench for pipe_id_hs: directed RV32I vectors, expected bundles queued on accept.
module tb_pipe_id_hs;

  localparam logic [4:0] A_ADD = 5'd0, A_SUB = 5'd1, A_SLT = 5'd3, A_SRA = 5'd7,
                         A_SEQ = 5'd10, A_PASS = 5'd11;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  alu_op;
    logic        alu_c;
    logic [31:0] opr1;
    logic [31:0] opr2;
    logic [31:0] val;
    logic        jp_e;
    logic        br_e;
    logic        wb_e;
    logic [1:0]  rw_e;
    logic [1:0]  rw_len;
    logic        illegal;
  } bnd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_inst, in_pc;
  logic [4:0]  rs1_idx, rs2_idx;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic        flush, out_valid, out_ready;
  logic [31:0] pc_out, opr1, opr2, val;
  logic [6:0]  op;
  logic [4:0]  rd, alu_op;
  logic        alu_c, jp_e, br_e, wb_e, illegal;
  logic [1:0]  rw_e, rw_len;

  int   checks = 0;
  int   errors = 0;
  bnd_t exp_q[$];

  always #5 clk = ~clk;

  // Register file model: xN reads as 0x1000+N, so x0 reading as 0 is visible.
  assign rs1_data = 32'h1000 + {27'd0, rs1_idx};
  assign rs2_data = 32'h1000 + {27'd0, rs2_idx};

  pipe_id_hs dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .op(op), .rd(rd), .alu_op(alu_op), .alu_c(alu_c),
    .opr1(opr1), .opr2(opr2), .val(val),
    .jp_e(jp_e), .br_e(br_e), .wb_e(wb_e), .rw_e(rw_e), .rw_len(rw_len), .illegal(illegal)
  );

  function automatic bnd_t cur();
    bnd_t b;
    b = '{pc_out, op, rd, alu_op, alu_c, opr1, opr2, val, jp_e, br_e, wb_e, rw_e, rw_len, illegal};
    return b;
  endfunction

  function automatic bnd_t ex(input logic [31:0] pc, input logic [31:0] inst,
                              input logic [4:0] aop, input logic c,
                              input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] v,
                              input logic jp, input logic br, input logic wb,
                              input logic [1:0] rwe, input logic [1:0] rwl, input logic ill);
    bnd_t b;
    b = '{pc, inst[6:0], inst[11:7], aop, c, o1, o2, v, jp, br, wb, rwe, rwl, ill};
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Holds in_valid until accepted; stall count must match the hand-derived hazard length.
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input bnd_t e,
                       input int exp_stall);
    int stalls = 0;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout pc=%h act=not_accepted exp=accepted", pc);
    end else if (stalls != exp_stall) begin
      errors++;
      $display("FAIL stall_cycles pc=%h act=%0d exp=%0d", pc, stalls, exp_stall);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && (out_ready || flush)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_bundle pc=%h act=%h exp=none", pc_out, cur());
      end else begin
        bnd_t e;
        e = exp_q.pop_front();
        if (cur() !== e) begin
          errors++;
          $display("FAIL bundle pc=%h act=%h exp=%h", e.pc, cur(), e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    wb_valid = 1'b0; wb_idx = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    checks++;
    if (cur() !== '0) begin
      errors++;
      $display("FAIL reset_bundle act=%h exp=0", cur());
    end
    @(posedge clk); #1;

    // addi x1,x0,5: x0 reads as 0 despite the regfile model
    issue(32'h00500093, 32'h100, ex(32'h100, 32'h00500093, A_ADD, 0, 0, 5, 0, 0, 0, 1, 0, 0, 0), 0);

    // add x2,x1,x1 stalls on RAW until x1 writes back 7, then takes the bypass
    fork
      issue(32'h00108133, 32'h104, ex(32'h104, 32'h00108133, A_ADD, 0, 7, 7, 0, 0, 0, 1, 0, 0, 0), 1);
      begin
        @(posedge clk); #1 wb_valid = 1'b1; wb_idx = 5'd1; wb_data = 32'd7;
        @(posedge clk); #1 wb_valid = 1'b0;
      end
    join
    idle(1);

    // lui x7 held for three cycles, jal x8,+16 waits behind it
    out_ready = 1'b0;
    issue(32'h123453B7, 32'h108, ex(32'h108, 32'h123453B7, A_PASS, 0, 32'h12345000, 0, 0, 0, 0, 1, 0, 0, 0), 0);
    fork
      issue(32'h0100046F, 32'h10C, ex(32'h10C, 32'h0100046F, A_ADD, 0, 16, 32'h10C, 4, 1, 0, 1, 0, 0, 0), 3);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("hold_out_valid", 64'(out_valid), 64'd1);
          chk("hold_pc", 64'(pc_out), 64'h108);
          chk("hold_opr1", 64'(opr1), 64'h12345000);
          chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    idle(1);

    // lw x3,-4(x4) held then flushed; add x9,x3,x0 proves sb[3] was released
    out_ready = 1'b0;
    issue(32'hFFC22183, 32'h110, ex(32'h110, 32'hFFC22183, A_ADD, 0, 32'h1004, 32'hFFFFFFFC, 0, 0, 0, 1, 2'b10, 2'b11, 0), 0);
    flush = 1'b1;
    fork
      issue(32'h000184B3, 32'h114, ex(32'h114, 32'h000184B3, A_ADD, 0, 32'h1003, 0, 0, 0, 0, 1, 0, 0, 0), 1);
      begin
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1 flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
      end
    join

    // bge x5,x6,-8 ; sb x5,1(x6) ; illegal opcode 0x7F with rd=4 ; add x10,x4,x0 must not stall
    issue(32'hFE62DCE3, 32'h118, ex(32'h118, 32'hFE62DCE3, A_SLT, 1, 32'h1005, 32'h1006, 32'hFFFFFFF8, 0, 1, 0, 0, 0, 0), 0);
    issue(32'h005300A3, 32'h11C, ex(32'h11C, 32'h005300A3, A_ADD, 0, 32'h1006, 1, 32'h1005, 0, 0, 0, 2'b01, 2'b00, 0), 0);
    issue(32'h0000027F, 32'h120, ex(32'h120, 32'h0000027F, A_PASS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 0);
    issue(32'h00020533, 32'h124, ex(32'h124, 32'h00020533, A_ADD, 0, 32'h1004, 0, 0, 0, 0, 1, 0, 0, 0), 0);
    // auipc x12,1 ; sub x13,x5,x6 ; srai x14,x5,3 ; lbu x15,2(x0)
    issue(32'h00001617, 32'h128, ex(32'h128, 32'h00001617, A_ADD, 0, 32'h128, 32'h1000, 0, 0, 0, 1, 0, 0, 0), 0);
    issue(32'h406286B3, 32'h12C, ex(32'h12C, 32'h406286B3, A_SUB, 0, 32'h1005, 32'h1006, 0, 0, 0, 1, 0, 0, 0), 0);
    issue(32'h4032D713, 32'h130, ex(32'h130, 32'h4032D713, A_SRA, 0, 32'h1005, 32'h403, 0, 0, 0, 1, 0, 0, 0), 0);
    issue(32'h00204783, 32'h134, ex(32'h134, 32'h00204783, A_ADD, 0, 0, 2, 0, 0, 0, 1, 2'b11, 2'b00, 0), 0);

    // WAW: second addi x1 waits for the first writer's writeback
    issue(32'h00500093, 32'h138, ex(32'h138, 32'h00500093, A_ADD, 0, 0, 5, 0, 0, 0, 1, 0, 0, 0), 0);
    fork
      issue(32'h00900093, 32'h13C, ex(32'h13C, 32'h00900093, A_ADD, 0, 0, 9, 0, 0, 0, 1, 0, 0, 0), 2);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1 wb_valid = 1'b1; wb_idx = 5'd1; wb_data = 32'h33;
        @(posedge clk); #1 wb_valid = 1'b0;
      end
    join

    // Set won over the same-cycle clear, so add x11,x1,x0 waits for the new writer
    fork
      issue(32'h000085B3, 32'h140, ex(32'h140, 32'h000085B3, A_ADD, 0, 32'h55, 0, 0, 0, 0, 1, 0, 0, 0), 1);
      begin
        @(posedge clk); #1 wb_valid = 1'b1; wb_idx = 5'd1; wb_data = 32'h55;
        @(posedge clk); #1 wb_valid = 1'b0;
      end
    join
    idle(3);
    chk("drain_queue", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_id_hs.md
Name: pipe_id_hs

Overview:
Parametrised, fully synchronous RV32I decode stage with a valid/ready handshake on both sides. It reads two register-file ports combinationally and tracks outstanding writebacks in a register scoreboard. RAW and WAW hazards stall the stage; writeback data is bypassed into the operands. A single output register feeds EX, and EX can flush that register on a taken branch or jump.

Parameters:
XLEN, 32, datapath width; all immediates sign-extend to XLEN (XLEN >= 32).
ALUOP_L, 5, alu_op width; encodings come from the shared ALU opcode header.
BYPASS_EN, 1, 1 = same-cycle writeback forwarding; 0 = stall until the scoreboard bit clears.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  IF holds an instruction
in_ready  out  1  ID accepts this cycle
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction PC
rs1_idx, rs2_idx  out  5  regfile read indices, combinational = in_inst[19:15], [24:20]
rs1_data, rs2_data  in  XLEN  regfile read data, same cycle
wb_valid  in  1  writeback commits this cycle
wb_idx  in  5  writeback register
wb_data  in  XLEN  writeback value
flush  in  1  kill the output register, block accept
out_valid  out  1  decoded bundle valid
out_ready  in  1  EX accepts the bundle
pc_out  out  XLEN  registered PC
op  out  7  registered inst[6:0]
rd  out  5  registered inst[11:7]
alu_op  out  ALUOP_L  ALU operation
alu_c  out  1  invert ALU result (BNE/BGE/BGEU)
opr1, opr2, val  out  XLEN  operands and auxiliary value
jp_e, br_e, wb_e  out  1  jump, branch, register-writeback enables
rw_e  out  2  00 none, 01 store, 10 signed load, 11 unsigned load
rw_len  out  2  00 byte, 01 half, 11 word
illegal  out  1  unknown opcode or funct3

Behaviour:
- Reset (rst=1 at a clk edge): every registered output = 0, scoreboard = 0, out_valid = 0. A reset mid-stall or mid-hold discards everything.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Accept = in_valid && in_ready. The output register loads on the next edge, so latency is 1 cycle.
- Hold: while out_valid && !out_ready && !flush, the outputs are stable.
- Otherwise, when not accepting, out_valid drops to 0 if the bundle was taken or flushed.
- Source usage:
  - rs1 is used by JALR, OP_IMM, LOAD, BRANCH, STORE, OP.
  - rs2 is used by BRANCH, STORE, OP.
  - Index 0 never hazards and reads as 0.
- Operand source:
  - If BYPASS_EN && wb_valid && wb_idx == rsN && rsN != 0, use wb_data.
  - Otherwise use rsN_data.
- hazard = (rs1 used && pend(rs1)) || (rs2 used && pend(rs2)) || (writes rd && rd != 0 && pend(rd)).
  - pend(i) = sb[i] && !(BYPASS_EN && wb_valid && wb_idx == i).
  - The WAW term guarantees at most one in-flight writer per register.
- Scoreboard update each edge:
  - Clear sb[wb_idx] on wb_valid.
  - Set sb[rd] on accept with wb_e && rd != 0.
  - Same index set and clear in one cycle: set wins.
  - On flush && out_valid && out_wb_e: clear sb[out_rd]. This has priority over an accept set, but accept is blocked during flush anyway.
- Decode (imm_I/S/B/U/J per RV32I, sign-extended to XLEN):
  - LUI: PASS, opr1 = imm_U, opr2 = 0.
  - AUIPC: ADD, opr1 = pc, opr2 = imm_U.
  - JAL: ADD, opr1 = imm_J, opr2 = pc, val = 4.
  - JALR: ADD, opr1 = rs1, opr2 = imm_I, val = 4.
  - OP_IMM: opr1 = rs1, opr2 = imm_I. funct3 maps to ADD/SLL/SRL or SRA (inst[30])/XOR/SLT/SLTU/OR/AND.
  - OP: opr1 = rs1, opr2 = rs2. ADD or SUB by inst[30], SRL or SRA by inst[30], remaining funct3 as OP_IMM.
  - LOAD: ADD, rs1 + imm_I. LB/LH/LW give rw_e = 10; LBU/LHU give rw_e = 11. rw_len = 00/01/11.
  - STORE: ADD, rs1 + imm_S, val = rs2, rw_e = 01. SB/SH/SW give rw_len = 00/01/11.
  - BRANCH: opr1 = rs1, opr2 = rs2, val = imm_B.
    - BEQ = SEQ; BNE = SEQ, alu_c = 1.
    - BLT = SLT; BGE = SLT, alu_c = 1.
    - BLTU = SLTU; BGEU = SLTU, alu_c = 1.
  - MISC_MEM: PASS, opr2 = 0, wb_e = 0.
  - SYSTEM: PASS, wb_e = 0.
  - Fields not listed for an opcode are 0.
- Flags:
  - jp_e = JAL | JALR; br_e = BRANCH.
  - wb_e = 0 for STORE, BRANCH, MISC_MEM, SYSTEM and illegal; 1 otherwise.
- Illegal instruction:
  - Undefined opcode or funct3 sets illegal = 1, alu_op = PASS, wb_e = 0, rw_e = 00.
  - The bundle is still delivered; no scoreboard set.

Test Plan:
- Reset → all outputs 0, in_ready = 1. Then addi x1,x0,5 with out_ready = 1 → next cycle out_valid = 1, alu_op = ADD, opr1 = 0, opr2 = 5, wb_e = 1, sb[1] = 1.
- RAW: add x2,x1,x1 while sb[1] set → in_ready = 0. With wb_valid, wb_idx = 1, wb_data = 7 (BYPASS_EN = 1) → accepted that cycle, opr1 = opr2 = 7.
- Backpressure: out_ready = 0 for 3 cycles → outputs stable, in_ready = 0. Release → the next instruction is accepted, no loss or duplication.
- Flush with a held `lw x3,-4(x4)` (opr2 = 0xFFFFFFFC, rw_e = 10, rw_len = 11) → out_valid = 0 next cycle, sb[3] = 0, in_ready = 0 during the flush.
- `bge x5,x6,-8` → alu_op = SLT, alu_c = 1, val = 0xFFFFFFF8, br_e = 1, wb_e = 0. `sb x5,1(x6)` → val = rs2 data, rw_e = 01, rw_len = 00.
- Opcode 0x7F → illegal = 1, wb_e = 0, scoreboard unchanged. WAW: `addi x1` while sb[1] set → stall until writeback.
